// File: rtl/axi4_cosim_pkg.sv
// Shared AXI constants and engine state encodings for the co-simulation master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4_cosim_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_AR,
      RD_R
   } rd_state_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_AW,
      WR_W,
      WR_B
   } wr_state_t;

endpackage

// File: rtl/axi4_beat_ctr.sv
// Beat index within one burst: cleared on load, advanced on each accepted beat.
// Latency: count updates one cycle after load/inc; is_last is combinational on the count.
// Backpressure: none; the caller only pulses inc on a completed handshake.
module axi4_beat_ctr (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       inc,
   input  logic [7:0] last_beat,
   output logic [7:0] cnt,
   output logic       is_last
);

   // Restart at beat 0 for a new burst, otherwise step once per accepted beat.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign is_last = (cnt == last_beat);

endmodule

// File: rtl/axi4_cosim_master.sv
// Turns one-cycle read/write requests into single AXI4 INCR bursts and returns a one-cycle done strobe.
// Latency: AR/AW valid one cycle after the request; response pulse one cycle after the last R beat / B handshake.
// Backpressure: requests arriving while the matching engine is busy are dropped; AXI channels honour ready/valid.
module axi4_cosim_master
   import axi4_cosim_pkg::*;
#(
   parameter int         TAGW = 3,
   parameter int         ADRW = 64,
   parameter int         DATW = 256,
   parameter logic [2:0] SIZE = 3'b101,
   parameter int         STBW = DATW / 8,
   parameter int         DTMP = 4096,
   parameter int         NSTB = DTMP / STBW
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   rd_req_valid,
   input  logic [ADRW-1:0]        rd_req_addr,
   input  logic [7:0]             rd_req_len,
   output logic                   rd_rsp_valid,
   output logic [DTMP*8-1:0]      rd_rsp_data,
   output logic                   rd_rsp_err,
   input  logic                   wr_req_valid,
   input  logic [ADRW-1:0]        wr_req_addr,
   input  logic [7:0]             wr_req_len,
   input  logic [DTMP*8-1:0]      wr_req_data,
   input  logic [NSTB*STBW-1:0]   wr_req_strb,
   output logic                   wr_rsp_valid,
   output logic                   wr_rsp_err,
   output logic                   rd_busy,
   output logic                   wr_busy,
   output logic [TAGW-1:0]        o_m_arid,
   output logic [ADRW-1:0]        o_m_araddr,
   output logic [7:0]             o_m_arlen,
   output logic [2:0]             o_m_arsize,
   output logic [1:0]             o_m_arburst,
   output logic                   o_m_arlock,
   output logic [3:0]             o_m_arcache,
   output logic [2:0]             o_m_arprot,
   output logic [3:0]             o_m_arregion,
   output logic                   o_m_arvalid,
   input  logic                   i_m_arready,
   input  logic [TAGW-1:0]        i_m_rid,
   input  logic [DATW-1:0]        i_m_rdata,
   input  logic [1:0]             i_m_rresp,
   input  logic                   i_m_rlast,
   input  logic                   i_m_rvalid,
   output logic                   o_m_rready,
   output logic [TAGW-1:0]        o_m_awid,
   output logic [ADRW-1:0]        o_m_awaddr,
   output logic [7:0]             o_m_awlen,
   output logic [2:0]             o_m_awsize,
   output logic [1:0]             o_m_awburst,
   output logic                   o_m_awlock,
   output logic [3:0]             o_m_awcache,
   output logic [2:0]             o_m_awprot,
   output logic [3:0]             o_m_awregion,
   output logic                   o_m_awvalid,
   input  logic                   i_m_awready,
   output logic [TAGW-1:0]        o_m_wid,
   output logic [DATW-1:0]        o_m_wdata,
   output logic                   o_m_wlast,
   output logic [STBW-1:0]        o_m_wstrb,
   output logic                   o_m_wvalid,
   input  logic                   i_m_wready,
   input  logic [TAGW-1:0]        i_m_bid,
   input  logic [1:0]             i_m_bresp,
   input  logic                   i_m_bvalid,
   output logic                   o_m_bready,
   input  logic                   intx_msi_request,
   output logic                   intx_msi_grant,
   output logic                   interrupt_out
);

   // Beat index width and bit offsets of one beat inside the request/response buffers.
   localparam int KW  = $clog2(NSTB);
   localparam int LDW = $clog2(DATW);
   localparam int LSW = $clog2(STBW);
   localparam logic [7:0] LEN_MAX = 8'(NSTB - 1);

   // Bursts longer than the buffer are truncated to the buffer size.
   function automatic logic [7:0] clamp_len(input logic [7:0] len);
      return (len > LEN_MAX) ? LEN_MAX : len;
   endfunction

   rd_state_t          rd_state;
   wr_state_t          wr_state;
   logic               rd_err;
   logic [7:0]         rd_k;
   logic [7:0]         wr_k;
   logic               rd_is_last;
   logic               wr_is_last;
   logic               rd_load;
   logic               wr_load;
   logic               rd_beat;
   logic               wr_beat;
   logic               rresp_bad;
   logic [KW+LDW-1:0]  rd_doff;
   logic [KW+LDW-1:0]  wr_doff;
   logic [KW+LSW-1:0]  wr_soff;
   logic [DTMP*8-1:0]  wr_data_q;
   logic [NSTB*STBW-1:0] wr_strb_q;
   logic               irq_req_q;
   logic               unused_ok;

   assign o_m_arid     = '0;
   assign o_m_arsize   = SIZE;
   assign o_m_arburst  = AXI_BURST_INCR;
   assign o_m_arlock   = 1'b0;
   assign o_m_arcache  = '0;
   assign o_m_arprot   = '0;
   assign o_m_arregion = '0;
   assign o_m_awid     = '0;
   assign o_m_awsize   = SIZE;
   assign o_m_awburst  = AXI_BURST_INCR;
   assign o_m_awlock   = 1'b0;
   assign o_m_awcache  = '0;
   assign o_m_awprot   = '0;
   assign o_m_awregion = '0;
   assign o_m_wid      = '0;

   assign rd_busy   = (rd_state != RD_IDLE);
   assign wr_busy   = (wr_state != WR_IDLE);
   assign rd_load   = (rd_state == RD_IDLE) && rd_req_valid;
   assign wr_load   = (wr_state == WR_IDLE) && wr_req_valid;
   assign rd_beat   = (rd_state == RD_R) && i_m_rvalid && o_m_rready;
   assign wr_beat   = o_m_wvalid && i_m_wready;
   assign rresp_bad = (i_m_rresp != AXI_RESP_OKAY);
   assign rd_doff   = {rd_k[KW-1:0], {LDW{1'b0}}};
   assign wr_doff   = {wr_k[KW-1:0], {LDW{1'b0}}};
   assign wr_soff   = {wr_k[KW-1:0], {LSW{1'b0}}};

   assign o_m_wdata = wr_data_q[wr_doff +: DATW];
   assign o_m_wstrb = wr_strb_q[wr_soff +: STBW];
   assign o_m_wlast = o_m_wvalid && wr_is_last;

   // Response IDs are fixed at zero, and the counters never exceed the clamped length.
   assign unused_ok = ^{i_m_rid, i_m_bid, rd_k[7:KW], wr_k[7:KW]};

   axi4_beat_ctr u_rd_ctr (
      .clk       (i_clk),
      .rst       (i_rst),
      .load      (rd_load),
      .inc       (rd_beat),
      .last_beat (o_m_arlen),
      .cnt       (rd_k),
      .is_last   (rd_is_last)
   );

   axi4_beat_ctr u_wr_ctr (
      .clk       (i_clk),
      .rst       (i_rst),
      .load      (wr_load),
      .inc       (wr_beat),
      .last_beat (o_m_awlen),
      .cnt       (wr_k),
      .is_last   (wr_is_last)
   );

   // Read engine: issue AR, collect beats into the response buffer, pulse done with sticky error.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_state     <= RD_IDLE;
         o_m_araddr   <= '0;
         o_m_arlen    <= '0;
         o_m_arvalid  <= 1'b0;
         o_m_rready   <= 1'b0;
         rd_err       <= 1'b0;
         rd_rsp_valid <= 1'b0;
         rd_rsp_err   <= 1'b0;
         rd_rsp_data  <= '0;
      end else begin
         rd_rsp_valid <= 1'b0;
         case (rd_state)
            RD_IDLE: begin
               if (rd_req_valid) begin
                  o_m_araddr  <= rd_req_addr;
                  o_m_arlen   <= clamp_len(rd_req_len);
                  o_m_arvalid <= 1'b1;
                  rd_err      <= 1'b0;
                  rd_state    <= RD_AR;
               end
            end
            RD_AR: begin
               if (i_m_arready) begin
                  o_m_arvalid <= 1'b0;
                  o_m_rready  <= 1'b1;
                  rd_state    <= RD_R;
               end
            end
            RD_R: begin
               if (rd_beat) begin
                  rd_rsp_data[rd_doff +: DATW] <= i_m_rdata;
                  rd_err <= rd_err | rresp_bad;
                  if (i_m_rlast || rd_is_last) begin
                     o_m_rready   <= 1'b0;
                     rd_rsp_valid <= 1'b1;
                     rd_rsp_err   <= rd_err | rresp_bad;
                     rd_state     <= RD_IDLE;
                  end
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   // Write engine: latch the request, issue AW, stream W beats after AW completes, then wait for B.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_state     <= WR_IDLE;
         o_m_awaddr   <= '0;
         o_m_awlen    <= '0;
         o_m_awvalid  <= 1'b0;
         o_m_wvalid   <= 1'b0;
         o_m_bready   <= 1'b0;
         wr_data_q    <= '0;
         wr_strb_q    <= '0;
         wr_rsp_valid <= 1'b0;
         wr_rsp_err   <= 1'b0;
      end else begin
         wr_rsp_valid <= 1'b0;
         case (wr_state)
            WR_IDLE: begin
               if (wr_req_valid) begin
                  o_m_awaddr  <= wr_req_addr;
                  o_m_awlen   <= clamp_len(wr_req_len);
                  wr_data_q   <= wr_req_data;
                  wr_strb_q   <= wr_req_strb;
                  o_m_awvalid <= 1'b1;
                  wr_state    <= WR_AW;
               end
            end
            WR_AW: begin
               if (i_m_awready) begin
                  o_m_awvalid <= 1'b0;
                  o_m_wvalid  <= 1'b1;
                  wr_state    <= WR_W;
               end
            end
            WR_W: begin
               if (wr_beat && wr_is_last) begin
                  o_m_wvalid <= 1'b0;
                  o_m_bready <= 1'b1;
                  wr_state   <= WR_B;
               end
            end
            WR_B: begin
               if (i_m_bvalid) begin
                  o_m_bready   <= 1'b0;
                  wr_rsp_valid <= 1'b1;
                  wr_rsp_err   <= (i_m_bresp != AXI_RESP_OKAY);
                  wr_state     <= WR_IDLE;
               end
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

   // Legacy interrupt handshake: one-cycle grant and interrupt on each request rising edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         irq_req_q      <= 1'b0;
         intx_msi_grant <= 1'b0;
         interrupt_out  <= 1'b0;
      end else begin
         irq_req_q      <= intx_msi_request;
         intx_msi_grant <= intx_msi_request && !irq_req_q;
         interrupt_out  <= intx_msi_request && !irq_req_q;
      end
   end

endmodule

// File: tb/tb_axi4_cosim_master.sv
// Randomized bench: the bench plays the AXI slave, generates data itself and checks bursts and responses.
module tb_axi4_cosim_master;

   localparam int DATW = 256;
   localparam int STBW = 32;
   localparam int DTMP = 4096;
   localparam int NSTB = DTMP / STBW;
   localparam int DW   = DTMP * 8;
   localparam int BOUND = 400;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   logic              rd_req_valid = 1'b0;
   logic [63:0]       rd_req_addr = '0;
   logic [7:0]        rd_req_len = '0;
   logic              rd_rsp_valid;
   logic [DW-1:0]     rd_rsp_data;
   logic              rd_rsp_err;
   logic              wr_req_valid = 1'b0;
   logic [63:0]       wr_req_addr = '0;
   logic [7:0]        wr_req_len = '0;
   logic [DW-1:0]     wr_req_data = '0;
   logic [DTMP-1:0]   wr_req_strb = '0;
   logic              wr_rsp_valid;
   logic              wr_rsp_err;
   logic              rd_busy;
   logic              wr_busy;
   logic [2:0]        o_m_arid;
   logic [63:0]       o_m_araddr;
   logic [7:0]        o_m_arlen;
   logic [2:0]        o_m_arsize;
   logic [1:0]        o_m_arburst;
   logic              o_m_arlock;
   logic [3:0]        o_m_arcache;
   logic [2:0]        o_m_arprot;
   logic [3:0]        o_m_arregion;
   logic              o_m_arvalid;
   logic              i_m_arready = 1'b0;
   logic [2:0]        i_m_rid = '0;
   logic [DATW-1:0]   i_m_rdata = '0;
   logic [1:0]        i_m_rresp = '0;
   logic              i_m_rlast = 1'b0;
   logic              i_m_rvalid = 1'b0;
   logic              o_m_rready;
   logic [2:0]        o_m_awid;
   logic [63:0]       o_m_awaddr;
   logic [7:0]        o_m_awlen;
   logic [2:0]        o_m_awsize;
   logic [1:0]        o_m_awburst;
   logic              o_m_awlock;
   logic [3:0]        o_m_awcache;
   logic [2:0]        o_m_awprot;
   logic [3:0]        o_m_awregion;
   logic              o_m_awvalid;
   logic              i_m_awready = 1'b0;
   logic [2:0]        o_m_wid;
   logic [DATW-1:0]   o_m_wdata;
   logic              o_m_wlast;
   logic [STBW-1:0]   o_m_wstrb;
   logic              o_m_wvalid;
   logic              i_m_wready = 1'b0;
   logic [2:0]        i_m_bid = '0;
   logic [1:0]        i_m_bresp = '0;
   logic              i_m_bvalid = 1'b0;
   logic              o_m_bready;
   logic              intx_msi_request = 1'b0;
   logic              intx_msi_grant;
   logic              interrupt_out;

   int n_vec = 0;
   int n_err = 0;
   int rd_rsp_cnt = 0;
   int wr_rsp_cnt = 0;
   int aw_hs_cnt = 0;

   always #5 i_clk = ~i_clk;

   axi4_cosim_master dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
      .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
      .wr_req_data(wr_req_data), .wr_req_strb(wr_req_strb),
      .wr_rsp_valid(wr_rsp_valid), .wr_rsp_err(wr_rsp_err), .rd_busy(rd_busy), .wr_busy(wr_busy),
      .o_m_arid(o_m_arid), .o_m_araddr(o_m_araddr), .o_m_arlen(o_m_arlen), .o_m_arsize(o_m_arsize),
      .o_m_arburst(o_m_arburst), .o_m_arlock(o_m_arlock), .o_m_arcache(o_m_arcache),
      .o_m_arprot(o_m_arprot), .o_m_arregion(o_m_arregion), .o_m_arvalid(o_m_arvalid),
      .i_m_arready(i_m_arready),
      .i_m_rid(i_m_rid), .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp), .i_m_rlast(i_m_rlast),
      .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready),
      .o_m_awid(o_m_awid), .o_m_awaddr(o_m_awaddr), .o_m_awlen(o_m_awlen), .o_m_awsize(o_m_awsize),
      .o_m_awburst(o_m_awburst), .o_m_awlock(o_m_awlock), .o_m_awcache(o_m_awcache),
      .o_m_awprot(o_m_awprot), .o_m_awregion(o_m_awregion), .o_m_awvalid(o_m_awvalid),
      .i_m_awready(i_m_awready),
      .o_m_wid(o_m_wid), .o_m_wdata(o_m_wdata), .o_m_wlast(o_m_wlast), .o_m_wstrb(o_m_wstrb),
      .o_m_wvalid(o_m_wvalid), .i_m_wready(i_m_wready),
      .i_m_bid(i_m_bid), .i_m_bresp(i_m_bresp), .i_m_bvalid(i_m_bvalid), .o_m_bready(o_m_bready),
      .intx_msi_request(intx_msi_request), .intx_msi_grant(intx_msi_grant),
      .interrupt_out(interrupt_out)
   );

   // Count response pulses and AW handshakes mid-cycle, where everything is stable.
   always @(negedge i_clk) begin
      if (rd_rsp_valid) rd_rsp_cnt++;
      if (wr_rsp_valid) wr_rsp_cnt++;
      if (o_m_awvalid && i_m_awready) aw_hs_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DATW-1:0] got, input logic [DATW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   function automatic int clamp(input int len);
      return (len > NSTB - 1) ? NSTB - 1 : len;
   endfunction

   task automatic fill_wr();
      for (int w = 0; w < DW / 32; w++) wr_req_data[w*32 +: 32] = $urandom;
      for (int w = 0; w < DTMP / 32; w++) wr_req_strb[w*32 +: 32] = $urandom;
   endtask

   task automatic rd_issue(input logic [63:0] addr, input logic [7:0] len);
      rd_req_addr = addr;
      rd_req_len = len;
      rd_req_valid = 1'b1;
      step();
      rd_req_valid = 1'b0;
   endtask

   task automatic wr_issue(input logic [63:0] addr, input logic [7:0] len);
      wr_req_addr = addr;
      wr_req_len = len;
      wr_req_valid = 1'b1;
      step();
      wr_req_valid = 1'b0;
   endtask

   // Slave side of one read burst; expected data is whatever the slave hands out.
   task automatic rd_slave(input logic [63:0] addr, input int len, input int err_beat,
                           input int ar_lat, input bit a5);
      logic [DATW-1:0] beats [NSTB];
      int n;
      int cnt0;
      bit any_err;
      cnt0 = rd_rsp_cnt;
      n = 0;
      while (!o_m_arvalid && n < BOUND) begin step(); n++; end
      chk("ar_valid", o_m_arvalid, 1);
      if (!o_m_arvalid) return;
      chk("ar_addr", o_m_araddr, addr);
      chk("ar_len", o_m_arlen, len);
      chk("ar_size", o_m_arsize, 3'b101);
      chk("ar_burst", o_m_arburst, 2'b01);
      chk("r_ready_in_ar", o_m_rready, 0);
      repeat (ar_lat) step();
      chk("ar_held", o_m_arvalid, 1);
      i_m_arready = 1'b1;
      step();
      i_m_arready = 1'b0;
      any_err = 1'b0;
      for (int i = 0; i <= len; i++) begin
         repeat ($urandom_range(0, 2)) step();
         if (a5) beats[i] = {32{8'hA5}};
         else for (int w = 0; w < DATW / 32; w++) beats[i][w*32 +: 32] = $urandom;
         i_m_rdata  = beats[i];
         i_m_rlast  = (i == len);
         i_m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
         i_m_rvalid = 1'b1;
         if (i == err_beat) any_err = 1'b1;
         n = 0;
         while (!o_m_rready && n < BOUND) begin step(); n++; end
         if (!o_m_rready) begin
            chk("r_ready", o_m_rready, 1);
            i_m_rvalid = 1'b0;
            return;
         end
         step();
         i_m_rvalid = 1'b0;
         i_m_rlast  = 1'b0;
         i_m_rresp  = 2'b00;
      end
      chk("rd_rsp_valid", rd_rsp_valid, 1);
      chk("rd_rsp_err", rd_rsp_err, any_err);
      chk("rd_busy_done", rd_busy, 0);
      chk("r_ready_done", o_m_rready, 0);
      for (int i = 0; i <= len; i++) chk("rd_beat", rd_rsp_data[i*DATW +: DATW], beats[i]);
      step();
      chk("rd_rsp_pulse", rd_rsp_valid, 0);
      chk("rd_rsp_count", rd_rsp_cnt - cnt0, 1);
   endtask

   // Slave side of one write burst; beats are checked against the request as issued.
   task automatic wr_slave(input logic [63:0] addr, input int len, input logic [1:0] bresp,
                           input bit toggle);
      logic [DW-1:0]   exp_d;
      logic [DTMP-1:0] exp_s;
      int n;
      int beat;
      int cnt0;
      exp_d = wr_req_data;
      exp_s = wr_req_strb;
      cnt0 = wr_rsp_cnt;
      n = 0;
      while (!o_m_awvalid && n < BOUND) begin step(); n++; end
      chk("aw_valid", o_m_awvalid, 1);
      if (!o_m_awvalid) return;
      chk("aw_addr", o_m_awaddr, addr);
      chk("aw_len", o_m_awlen, len);
      chk("w_before_aw", o_m_wvalid, 0);
      repeat ($urandom_range(0, 2)) begin
         step();
         chk("w_before_aw", o_m_wvalid, 0);
      end
      i_m_awready = 1'b1;
      step();
      i_m_awready = 1'b0;
      beat = 0;
      n = 0;
      while (beat <= len && n < 8 * (len + 1) + 50) begin
         i_m_wready = toggle ? ((n % 2) == 1) : ($urandom_range(0, 1) == 1);
         if (o_m_wvalid && i_m_wready) begin
            chk("w_data", o_m_wdata, exp_d[beat*DATW +: DATW]);
            chk("w_strb", o_m_wstrb, exp_s[beat*STBW +: STBW]);
            chk("w_last", o_m_wlast, beat == len);
            beat++;
         end
         step();
         n++;
      end
      i_m_wready = 1'b0;
      chk("w_beats", beat, len + 1);
      chk("w_valid_off", o_m_wvalid, 0);
      chk("b_ready", o_m_bready, 1);
      repeat ($urandom_range(0, 2)) step();
      i_m_bresp = bresp;
      i_m_bvalid = 1'b1;
      step();
      i_m_bvalid = 1'b0;
      chk("wr_rsp_valid", wr_rsp_valid, 1);
      chk("wr_rsp_err", wr_rsp_err, bresp != 2'b00);
      chk("wr_busy_done", wr_busy, 0);
      step();
      chk("wr_rsp_pulse", wr_rsp_valid, 0);
      chk("wr_rsp_count", wr_rsp_cnt - cnt0, 1);
   endtask

   initial begin
      int aw0;
      int w0;
      int g;
      int io;

      repeat (3) step();
      chk("rst_arvalid", o_m_arvalid, 0);
      chk("rst_awvalid", o_m_awvalid, 0);
      chk("rst_wvalid", o_m_wvalid, 0);
      chk("rst_rready", o_m_rready, 0);
      chk("rst_bready", o_m_bready, 0);
      chk("rst_busy", {rd_busy, wr_busy}, 0);
      chk("rst_rsp", {rd_rsp_valid, wr_rsp_valid}, 0);
      chk("rst_irq", {intx_msi_grant, interrupt_out}, 0);
      chk("rst_rd_data", rd_rsp_data[DATW-1:0], 0);
      i_rst = 1'b0;
      step();

      // Single-beat read with arready one cycle late.
      rd_issue(64'h1000, 8'd0);
      chk("rd_busy", rd_busy, 1);
      rd_slave(64'h1000, 0, -1, 1, 1'b1);

      // Four-beat write, first strobe 0xF, wready toggling.
      fill_wr();
      wr_req_strb = '1;
      wr_req_strb[31:0] = 32'h0000000F;
      wr_issue(64'h2000, 8'd3);
      chk("wr_busy", wr_busy, 1);
      wr_slave(64'h2000, 3, 2'b00, 1'b1);

      // Error responses.
      fill_wr();
      wr_issue(64'h3000, 8'd1);
      wr_slave(64'h3000, 1, 2'b10, 1'b0);
      rd_issue(64'h4000, 8'd1);
      rd_slave(64'h4000, 1, 1, 0, 1'b0);

      // Write request while busy is dropped.
      aw0 = aw_hs_cnt;
      w0 = wr_rsp_cnt;
      fill_wr();
      wr_issue(64'h5000, 8'd5);
      fork
         wr_slave(64'h5000, 5, 2'b00, 1'b0);
         begin
            step();
            step();
            wr_req_addr = 64'hDEAD_0000;
            wr_req_len = 8'd0;
            wr_req_valid = 1'b1;
            step();
            wr_req_valid = 1'b0;
         end
      join
      repeat (4) step();
      chk("drop_aw", aw_hs_cnt - aw0, 1);
      chk("drop_rsp", wr_rsp_cnt - w0, 1);
      chk("drop_idle", wr_busy, 0);

      // Oversized lengths clamp to the buffer, read and write concurrently.
      fill_wr();
      fork
         begin rd_issue(64'h7000, 8'd200); rd_slave(64'h7000, NSTB - 1, -1, 0, 1'b0); end
         begin wr_issue(64'h8000, 8'd255); wr_slave(64'h8000, NSTB - 1, 2'b00, 1'b0); end
      join

      // Random mix of reads, writes and concurrent pairs.
      for (int it = 0; it < 16; it++) begin
         int mode;
         int rl;
         int wl;
         int eb;
         logic [63:0] ra;
         logic [63:0] wa;
         logic [1:0] br;
         mode = $urandom_range(0, 2);
         rl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
         wl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
         ra = {$urandom, $urandom};
         wa = {$urandom, $urandom};
         eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, clamp(rl)) : -1;
         br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         fill_wr();
         fork
            begin
               if (mode != 1) begin
                  rd_issue(ra, 8'(rl));
                  rd_slave(ra, clamp(rl), eb, $urandom_range(0, 3), 1'b0);
               end
            end
            begin
               if (mode != 0) begin
                  wr_issue(wa, 8'(wl));
                  wr_slave(wa, clamp(wl), br, 1'b0);
               end
            end
         join
      end

      // Reset in the middle of a write data phase.
      fill_wr();
      wr_issue(64'h6000, 8'd7);
      i_m_awready = 1'b1;
      step();
      i_m_awready = 1'b0;
      i_m_wready = 1'b1;
      step();
      step();
      chk("w_mid", o_m_wvalid, 1);
      w0 = wr_rsp_cnt;
      i_rst = 1'b1;
      step();
      i_m_wready = 1'b0;
      chk("rst_mid_wvalid", o_m_wvalid, 0);
      chk("rst_mid_bready", o_m_bready, 0);
      chk("rst_mid_busy", wr_busy, 0);
      chk("rst_mid_rd_data", rd_rsp_data[DATW-1:0], 0);
      i_rst = 1'b0;
      repeat (5) step();
      chk("rst_mid_no_rsp", wr_rsp_cnt - w0, 0);
      chk("rst_mid_idle", o_m_wvalid, 0);

      // Interrupt handshake on a request rising edge.
      g = 0;
      io = 0;
      intx_msi_request = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         g += int'(intx_msi_grant);
         io += int'(interrupt_out);
         chk("irq_align", interrupt_out, intx_msi_grant);
      end
      chk("irq_grant_cycles", g, 1);
      chk("irq_out_cycles", io, 1);
      intx_msi_request = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
